// File: rtl/rob_ctrl.sv
// Reorder buffer controller: allocates entries in program order, collects
// out-of-order completions, retires in order and halts on a faulting entry.
module rob_ctrl #(
  parameter int DEPTH        = 16,
  parameter int ISSUE_WIDTH  = 2,
  parameter int CPL_PORTS    = 3,
  parameter int COMMIT_WIDTH = 2,
  parameter int XLEN         = 32,
  parameter int IDX_W        = $clog2(DEPTH)
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic                                i_flush,
  output logic                                o_rob_avail,
  output logic [ISSUE_WIDTH-1:0][IDX_W-1:0]   o_rob_idx,
  input  logic [ISSUE_WIDTH-1:0]              i_alloc_valid,
  input  logic [ISSUE_WIDTH-1:0]              i_alloc_rd_valid,
  input  logic [ISSUE_WIDTH-1:0][4:0]         i_alloc_rd_idx,
  input  logic [CPL_PORTS-1:0]                i_cpl_valid,
  input  logic [CPL_PORTS-1:0][IDX_W-1:0]     i_cpl_idx,
  input  logic [CPL_PORTS-1:0][XLEN-1:0]      i_cpl_data,
  input  logic [CPL_PORTS-1:0]                i_cpl_except,
  output logic [COMMIT_WIDTH-1:0]             o_int_reg_wb_valid,
  output logic [COMMIT_WIDTH-1:0][4:0]        o_int_reg_wb_idx,
  output logic [COMMIT_WIDTH-1:0][XLEN-1:0]   o_int_reg_wb_data,
  output logic                                o_except,
  output logic [IDX_W-1:0]                    o_except_idx,
  output logic                                o_halted
);
  localparam logic [0:0]     S_RUN   = 1'b0;
  localparam logic [0:0]     S_HALT  = 1'b1;
  localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0] ISSUE_C = (IDX_W+1)'(ISSUE_WIDTH);

  logic [0:0]                 state_q, state_d;
  logic [IDX_W-1:0]           head_q, head_d, tail_q, tail_d;
  logic [IDX_W:0]             count_q, count_d;
  logic [DEPTH-1:0]           valid_q, done_q, exc_q, rdv_q;
  logic [DEPTH-1:0][4:0]      rd_q;
  logic [DEPTH-1:0][XLEN-1:0] data_q;

  logic [COMMIT_WIDTH-1:0]            wb_valid_q, wb_valid_d;
  logic [COMMIT_WIDTH-1:0][4:0]       wb_idx_q, wb_idx_d;
  logic [COMMIT_WIDTH-1:0][XLEN-1:0]  wb_data_q, wb_data_d;
  logic                               except_q;
  logic [IDX_W-1:0]                   except_idx_q, except_idx_d;

  logic [ISSUE_WIDTH-1:0]              alloc_en;
  logic [ISSUE_WIDTH-1:0][IDX_W-1:0]   alloc_idx;
  logic [COMMIT_WIDTH-1:0]             retire;
  logic [COMMIT_WIDTH-1:0][IDX_W-1:0]  ret_idx;
  logic [IDX_W:0]                      n_alloc, n_ret;
  logic                                fault, chain, cpl_dup;

  assign o_rob_avail        = (state_q == S_RUN) && ((DEPTH_C - count_q) >= ISSUE_C);
  assign o_halted           = (state_q == S_HALT);
  assign o_int_reg_wb_valid = wb_valid_q;
  assign o_int_reg_wb_idx   = wb_idx_q;
  assign o_int_reg_wb_data  = wb_data_q;
  assign o_except           = except_q;
  assign o_except_idx       = except_idx_q;

  always_comb begin
    alloc_en  = '0;
    alloc_idx = '0;
    o_rob_idx = '0;
    n_alloc   = '0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      alloc_idx[k] = tail_q + IDX_W'(k);
      o_rob_idx[k] = alloc_idx[k];
      alloc_en[k]  = i_alloc_valid[k] & o_rob_avail;
      n_alloc      = n_alloc + (IDX_W+1)'(alloc_en[k]);
    end
  end

  // A slot retires only if every older slot retired cleanly this cycle.
  always_comb begin
    retire       = '0;
    ret_idx      = '0;
    n_ret        = '0;
    fault        = 1'b0;
    except_idx_d = '0;
    wb_valid_d   = '0;
    wb_idx_d     = '0;
    wb_data_d    = '0;
    chain        = (state_q == S_RUN);
    for (int j = 0; j < COMMIT_WIDTH; j++) begin
      ret_idx[j] = head_q + IDX_W'(j);
      if (chain && ((IDX_W+1)'(j) < count_q) && valid_q[ret_idx[j]] && done_q[ret_idx[j]]) begin
        retire[j] = 1'b1;
        n_ret     = n_ret + (IDX_W+1)'(1);
        if (exc_q[ret_idx[j]]) begin
          fault        = 1'b1;
          except_idx_d = ret_idx[j];
          chain        = 1'b0;
        end else if (rdv_q[ret_idx[j]] && (rd_q[ret_idx[j]] != 5'd0)) begin
          wb_valid_d[j] = 1'b1;
          wb_idx_d[j]   = rd_q[ret_idx[j]];
          wb_data_d[j]  = data_q[ret_idx[j]];
        end
      end else begin
        chain = 1'b0;
      end
    end
  end

  always_comb begin
    head_d  = head_q + n_ret[IDX_W-1:0];
    tail_d  = tail_q + n_alloc[IDX_W-1:0];
    count_d = count_q + n_alloc - n_ret;
    state_d = fault ? S_HALT : state_q;
    if (i_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      state_d = S_RUN;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_RUN;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      wb_valid_q   <= '0;
      wb_idx_q     <= '0;
      wb_data_q    <= '0;
      except_q     <= 1'b0;
      except_idx_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (i_flush) begin
        wb_valid_q   <= '0;
        wb_idx_q     <= '0;
        wb_data_q    <= '0;
        except_q     <= 1'b0;
        except_idx_q <= '0;
      end else begin
        wb_valid_q   <= wb_valid_d;
        wb_idx_q     <= wb_idx_d;
        wb_data_q    <= wb_data_d;
        except_q     <= fault;
        except_idx_q <= except_idx_d;
      end
    end
  end

  // Retire, allocate and complete never touch the same entry in one cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= '0;
      done_q  <= '0;
      exc_q   <= '0;
      rdv_q   <= '0;
      rd_q    <= '0;
      data_q  <= '0;
    end else if (i_flush) begin
      valid_q <= '0;
      done_q  <= '0;
      exc_q   <= '0;
    end else begin
      for (int j = 0; j < COMMIT_WIDTH; j++) begin
        if (retire[j]) valid_q[ret_idx[j]] <= 1'b0;
      end
      for (int k = 0; k < ISSUE_WIDTH; k++) begin
        if (alloc_en[k]) begin
          valid_q[alloc_idx[k]] <= 1'b1;
          done_q[alloc_idx[k]]  <= 1'b0;
          exc_q[alloc_idx[k]]   <= 1'b0;
          rdv_q[alloc_idx[k]]   <= i_alloc_rd_valid[k];
          rd_q[alloc_idx[k]]    <= i_alloc_rd_idx[k];
        end
      end
      for (int p = 0; p < CPL_PORTS; p++) begin
        if (i_cpl_valid[p] && valid_q[i_cpl_idx[p]] && !done_q[i_cpl_idx[p]]) begin
          done_q[i_cpl_idx[p]] <= 1'b1;
          exc_q[i_cpl_idx[p]]  <= i_cpl_except[p];
          data_q[i_cpl_idx[p]] <= i_cpl_data[p];
        end
      end
    end
  end

  always_comb begin
    cpl_dup = 1'b0;
    for (int p = 0; p < CPL_PORTS; p++) begin
      for (int q = p + 1; q < CPL_PORTS; q++) begin
        if (i_cpl_valid[p] && i_cpl_valid[q] && (i_cpl_idx[p] == i_cpl_idx[q])) cpl_dup = 1'b1;
      end
    end
  end

  a_alloc_contig: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (i_alloc_valid & (i_alloc_valid + ISSUE_WIDTH'(1))) == '0);
  a_cpl_unique: assert property (@(posedge i_clk) disable iff (!i_rst_n) !cpl_dup);

endmodule

// File: tb/tb_rob_ctrl.sv
// Bench for rob_ctrl: per-cycle vector table plus directed sequences, with a
// writeback scoreboard filled in program order at allocation time.
module tb_rob_ctrl;
  localparam int DEPTH = 16;
  localparam int IDX_W = 4;
  localparam int XLEN  = 32;

  logic                  clk   = 1'b0;
  logic                  rst_n = 1'b1;
  logic                  flush = 1'b0;
  logic                  rob_avail;
  logic [1:0][IDX_W-1:0] rob_idx;
  logic [1:0]            alloc_valid = '0, alloc_rd_valid = '0;
  logic [1:0][4:0]       alloc_rd_idx = '0;
  logic [2:0]            cpl_valid = '0, cpl_except = '0;
  logic [2:0][IDX_W-1:0] cpl_idx = '0;
  logic [2:0][XLEN-1:0]  cpl_data = '0;
  logic [1:0]            wb_valid;
  logic [1:0][4:0]       wb_idx;
  logic [1:0][XLEN-1:0]  wb_data;
  logic                  except_o, halted;
  logic [IDX_W-1:0]      except_idx;

  always #5 clk = ~clk;

  rob_ctrl #(.DEPTH(DEPTH), .ISSUE_WIDTH(2), .CPL_PORTS(3), .COMMIT_WIDTH(2),
             .XLEN(XLEN), .IDX_W(IDX_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .o_rob_avail(rob_avail), .o_rob_idx(rob_idx),
    .i_alloc_valid(alloc_valid), .i_alloc_rd_valid(alloc_rd_valid), .i_alloc_rd_idx(alloc_rd_idx),
    .i_cpl_valid(cpl_valid), .i_cpl_idx(cpl_idx), .i_cpl_data(cpl_data), .i_cpl_except(cpl_except),
    .o_int_reg_wb_valid(wb_valid), .o_int_reg_wb_idx(wb_idx), .o_int_reg_wb_data(wb_data),
    .o_except(except_o), .o_except_idx(except_idx), .o_halted(halted));

  typedef struct packed {
    logic [1:0]  av;
    logic [1:0]  rdv;
    logic [4:0]  rd0;
    logic [4:0]  rd1;
    logic [2:0]  cv;
    logic [3:0]  ci0;
    logic [31:0] cd0;
    logic [3:0]  ci1;
    logic [31:0] cd1;
    logic [3:0]  ci2;
    logic [31:0] cd2;
    logic [2:0]  cx;
    logic        fl;
    logic        e_av;
    logic [3:0]  e_idx0;
    logic [1:0]  e_wbv;
    logic        e_exc;
    logic [3:0]  e_exci;
    logic        e_halt;
  } vec_t;

  typedef struct packed {
    logic [3:0] idx;
    logic [4:0] rd;
  } sb_t;

  vec_t        tbl [17];
  sb_t         sb [$];
  logic [31:0] cdata [DEPTH];
  logic [15:0] calloc = '0, cdone = '0;
  logic [3:0]  m_tail = '0;
  logic        cur_avail = 1'b1;
  int          nvec = 0, nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] av, input logic [1:0] rdv,
                              input logic [4:0] rd0, input logic [4:0] rd1,
                              input logic [2:0] cv, input logic [3:0] ci0, input logic [31:0] cd0,
                              input logic [3:0] ci1, input logic [31:0] cd1, input logic fl,
                              input logic e_av, input logic [3:0] e_idx0, input logic [1:0] e_wbv);
    vec_t v;
    v = '0;
    v.av = av; v.rdv = rdv; v.rd0 = rd0; v.rd1 = rd1;
    v.cv = cv; v.ci0 = ci0; v.cd0 = cd0; v.ci1 = ci1; v.cd1 = cd1; v.fl = fl;
    v.e_av = e_av; v.e_idx0 = e_idx0; v.e_wbv = e_wbv;
    return v;
  endfunction

  task automatic clear_model();
    sb.delete();
    m_tail = '0;
    calloc = '0;
    cdone  = '0;
  endtask

  // Drive one cycle, track expected writes, then check outputs 1ns after the edge.
  task automatic cyc(input vec_t v);
    logic [3:0]  ci [3];
    logic [31:0] cd [3];
    logic [3:0]  i1;
    sb_t         e;
    ci[0] = v.ci0; ci[1] = v.ci1; ci[2] = v.ci2;
    cd[0] = v.cd0; cd[1] = v.cd1; cd[2] = v.cd2;
    alloc_valid = v.av; alloc_rd_valid = v.rdv; alloc_rd_idx = {v.rd1, v.rd0};
    cpl_valid = v.cv; cpl_idx = {v.ci2, v.ci1, v.ci0}; cpl_data = {v.cd2, v.cd1, v.cd0};
    cpl_except = v.cx; flush = v.fl;
    if (v.fl) begin
      clear_model();
    end else begin
      for (int p = 0; p < 3; p++) begin
        if (v.cv[p] && calloc[ci[p]] && !cdone[ci[p]]) begin
          cdone[ci[p]] = 1'b1;
          cdata[ci[p]] = cd[p];
        end
      end
      if (cur_avail) begin
        for (int k = 0; k < 2; k++) begin
          if (v.av[k]) begin
            e.idx = m_tail + 4'(k);
            e.rd  = (k == 0) ? v.rd0 : v.rd1;
            calloc[e.idx] = 1'b1;
            cdone[e.idx]  = 1'b0;
            if (v.rdv[k] && e.rd != 5'd0) sb.push_back(e);
          end
        end
        m_tail = m_tail + 4'(v.av[0]) + 4'(v.av[1]);
      end
    end
    @(posedge clk);
    #1;
    i1 = v.e_idx0 + 4'd1;
    chk("avail",      32'(rob_avail),  32'(v.e_av));
    chk("rob_idx0",   32'(rob_idx[0]), 32'(v.e_idx0));
    chk("rob_idx1",   32'(rob_idx[1]), 32'(i1));
    chk("wb_valid",   32'(wb_valid),   32'(v.e_wbv));
    chk("except",     32'(except_o),   32'(v.e_exc));
    chk("except_idx", 32'(except_idx), 32'(v.e_exci));
    chk("halted",     32'(halted),     32'(v.e_halt));
    cur_avail = v.e_av;
    for (int j = 0; j < 2; j++) begin
      if (wb_valid[j]) begin
        if (sb.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL wb_unexpected: slot %0d wrote x%0d=0x%0h, none expected", j, wb_idx[j], wb_data[j]);
        end else begin
          e = sb.pop_front();
          chk("wb_rd",   32'(wb_idx[j]), 32'(e.rd));
          chk("wb_data", wb_data[j],     cdata[e.idx]);
        end
      end else begin
        chk("wb_idle", 32'(wb_idx[j]) | wb_data[j], 32'd0);
      end
    end
  endtask

  initial begin
    //          av    rdv   rd0   rd1   cv     ci0   cd0      ci1   cd1      ci2   cd2      cx     fl    e_av  idx0  wbv    exc   exci  halt
    tbl[0]  = '{2'b11,2'b11,5'd5, 5'd6, 3'b000,4'd0, 32'h0,   4'd0, 32'h0,   4'd0, 32'h0,   3'b000,1'b0, 1'b1, 4'd2, 2'b00, 1'b0, 4'd0, 1'b0};
    tbl[1]  = '{2'b00,2'b00,5'd0, 5'd0, 3'b001,4'd1, 32'hA,   4'd0, 32'h0,   4'd0, 32'h0,   3'b000,1'b0, 1'b1, 4'd2, 2'b00, 1'b0, 4'd0, 1'b0};
    tbl[2]  = '{2'b00,2'b00,5'd0, 5'd0, 3'b001,4'd0, 32'hB,   4'd0, 32'h0,   4'd0, 32'h0,   3'b000,1'b0, 1'b1, 4'd2, 2'b00, 1'b0, 4'd0, 1'b0};
    tbl[3]  = '{2'b00,2'b00,5'd0, 5'd0, 3'b000,4'd0, 32'h0,   4'd0, 32'h0,   4'd0, 32'h0,   3'b000,1'b0, 1'b1, 4'd2, 2'b11, 1'b0, 4'd0, 1'b0};
    tbl[4]  = '{2'b00,2'b00,5'd0, 5'd0, 3'b000,4'd0, 32'h0,   4'd0, 32'h0,   4'd0, 32'h0,   3'b000,1'b0, 1'b1, 4'd2, 2'b00, 1'b0, 4'd0, 1'b0};
    tbl[5]  = '{2'b01,2'b01,5'd0, 5'd0, 3'b000,4'd0, 32'h0,   4'd0, 32'h0,   4'd0, 32'h0,   3'b000,1'b0, 1'b1, 4'd3, 2'b00, 1'b0, 4'd0, 1'b0};
    tbl[6]  = '{2'b00,2'b00,5'd0, 5'd0, 3'b010,4'd0, 32'h0,   4'd2, 32'h33,  4'd0, 32'h0,   3'b000,1'b0, 1'b1, 4'd3, 2'b00, 1'b0, 4'd0, 1'b0};
    tbl[7]  = '{2'b00,2'b00,5'd0, 5'd0, 3'b000,4'd0, 32'h0,   4'd0, 32'h0,   4'd0, 32'h0,   3'b000,1'b0, 1'b1, 4'd3, 2'b00, 1'b0, 4'd0, 1'b0};
    tbl[8]  = '{2'b11,2'b11,5'd7, 5'd8, 3'b000,4'd0, 32'h0,   4'd0, 32'h0,   4'd0, 32'h0,   3'b000,1'b0, 1'b1, 4'd5, 2'b00, 1'b0, 4'd0, 1'b0};
    tbl[9]  = '{2'b00,2'b00,5'd0, 5'd0, 3'b011,4'd4, 32'h44,  4'd3, 32'h77,  4'd0, 32'h0,   3'b001,1'b0, 1'b1, 4'd5, 2'b00, 1'b0, 4'd0, 1'b0};
    tbl[10] = '{2'b00,2'b00,5'd0, 5'd0, 3'b000,4'd0, 32'h0,   4'd0, 32'h0,   4'd0, 32'h0,   3'b000,1'b0, 1'b0, 4'd5, 2'b01, 1'b1, 4'd4, 1'b1};
    tbl[11] = '{2'b11,2'b11,5'd9, 5'd10,3'b000,4'd0, 32'h0,   4'd0, 32'h0,   4'd0, 32'h0,   3'b000,1'b0, 1'b0, 4'd5, 2'b00, 1'b0, 4'd0, 1'b1};
    tbl[12] = '{2'b11,2'b11,5'd1, 5'd2, 3'b001,4'd5, 32'h55,  4'd0, 32'h0,   4'd0, 32'h0,   3'b000,1'b1, 1'b1, 4'd0, 2'b00, 1'b0, 4'd0, 1'b0};
    tbl[13] = '{2'b11,2'b11,5'd1, 5'd2, 3'b000,4'd0, 32'h0,   4'd0, 32'h0,   4'd0, 32'h0,   3'b000,1'b0, 1'b1, 4'd2, 2'b00, 1'b0, 4'd0, 1'b0};
    tbl[14] = '{2'b00,2'b00,5'd0, 5'd0, 3'b101,4'd1, 32'hC1,  4'd0, 32'h0,   4'd0, 32'hC0,  3'b000,1'b0, 1'b1, 4'd2, 2'b00, 1'b0, 4'd0, 1'b0};
    tbl[15] = '{2'b00,2'b00,5'd0, 5'd0, 3'b000,4'd0, 32'h0,   4'd0, 32'h0,   4'd0, 32'h0,   3'b000,1'b0, 1'b1, 4'd2, 2'b11, 1'b0, 4'd0, 1'b0};
    tbl[16] = '{2'b00,2'b00,5'd0, 5'd0, 3'b000,4'd0, 32'h0,   4'd0, 32'h0,   4'd0, 32'h0,   3'b000,1'b0, 1'b1, 4'd2, 2'b00, 1'b0, 4'd0, 1'b0};

    #1 rst_n = 1'b0;
    #2;
    chk("rst_avail",  32'(rob_avail),  32'd1);
    chk("rst_idx0",   32'(rob_idx[0]), 32'd0);
    chk("rst_idx1",   32'(rob_idx[1]), 32'd1);
    chk("rst_wbv",    32'(wb_valid),   32'd0);
    chk("rst_except", 32'(except_o),   32'd0);
    chk("rst_halted", 32'(halted),     32'd0);
    #9 rst_n = 1'b1;

    // out-of-order completion, x0 writes, fault/halt/flush
    for (int i = 0; i < 17; i++) cyc(tbl[i]);

    // fill to DEPTH with tail wrap, retire two, then reach count 15
    cyc(mk('0, '0, '0, '0, '0, '0, '0, '0, '0, 1'b1, 1'b1, 4'd0, 2'b00));
    for (int k = 1; k <= 8; k++)
      cyc(mk(2'b11, 2'b11, 5'(2*k-1), 5'(2*k), '0, '0, '0, '0, '0, 1'b0, 1'(k < 8), 4'(2*k), 2'b00));
    cyc(mk('0, '0, '0, '0, 3'b011, 4'd0, 32'hF0, 4'd1, 32'hF1, 1'b0, 1'b0, 4'd0, 2'b00));
    cyc(mk('0, '0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b1, 4'd0, 2'b11));
    cyc(mk(2'b01, 2'b01, 5'd20, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 4'd1, 2'b00));
    cyc(mk(2'b11, 2'b11, 5'd21, 5'd22, '0, '0, '0, '0, '0, 1'b0, 1'b0, 4'd1, 2'b00));
    cyc(mk('0, '0, '0, '0, '0, '0, '0, '0, '0, 1'b1, 1'b1, 4'd0, 2'b00));

    // completion to an unallocated entry and a duplicate completion
    cyc(mk(2'b01, 2'b01, 5'd9, '0, '0, '0, '0, '0, '0, 1'b0, 1'b1, 4'd1, 2'b00));
    cyc(mk('0, '0, '0, '0, 3'b001, 4'd5, 32'hBAD, '0, '0, 1'b0, 1'b1, 4'd1, 2'b00));
    cyc(mk('0, '0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b1, 4'd1, 2'b00));
    cyc(mk(2'b11, 2'b11, 5'd10, 5'd11, '0, '0, '0, '0, '0, 1'b0, 1'b1, 4'd3, 2'b00));
    cyc(mk('0, '0, '0, '0, 3'b001, 4'd2, 32'h22, '0, '0, 1'b0, 1'b1, 4'd3, 2'b00));
    cyc(mk('0, '0, '0, '0, 3'b001, 4'd2, 32'hEE, '0, '0, 1'b0, 1'b1, 4'd3, 2'b00));
    cyc(mk('0, '0, '0, '0, 3'b011, 4'd0, 32'h99, 4'd1, 32'h11, 1'b0, 1'b1, 4'd3, 2'b00));
    cyc(mk('0, '0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b1, 4'd3, 2'b11));
    cyc(mk('0, '0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b1, 4'd3, 2'b01));
    cyc(mk('0, '0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b1, 4'd3, 2'b00));

    // async reset while writebacks are visible and entries are in flight
    cyc(mk(2'b11, 2'b11, 5'd12, 5'd13, '0, '0, '0, '0, '0, 1'b0, 1'b1, 4'd5, 2'b00));
    cyc(mk('0, '0, '0, '0, 3'b011, 4'd3, 32'h3333, 4'd4, 32'h4444, 1'b0, 1'b1, 4'd5, 2'b00));
    cyc(mk(2'b11, 2'b11, 5'd14, 5'd15, '0, '0, '0, '0, '0, 1'b0, 1'b1, 4'd7, 2'b11));
    alloc_valid = '0;
    cpl_valid   = 3'b001;
    cpl_idx     = {4'd0, 4'd0, 4'd5};
    cpl_data    = {32'h0, 32'h0, 32'h55};
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wbv",    32'(wb_valid),   32'd0);
    chk("arst_wbdata", wb_data[0] | wb_data[1], 32'd0);
    chk("arst_avail",  32'(rob_avail),  32'd1);
    chk("arst_idx0",   32'(rob_idx[0]), 32'd0);
    chk("arst_idx1",   32'(rob_idx[1]), 32'd1);
    chk("arst_halted", 32'(halted),     32'd0);
    clear_model();
    cur_avail = 1'b1;
    cpl_valid = '0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    cyc(mk('0, '0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b1, 4'd0, 2'b00));
    cyc(mk(2'b11, 2'b11, 5'd3, 5'd4, '0, '0, '0, '0, '0, 1'b0, 1'b1, 4'd2, 2'b00));
    cyc(mk('0, '0, '0, '0, 3'b011, 4'd0, 32'hA0, 4'd1, 32'hA1, 1'b0, 1'b1, 4'd2, 2'b00));
    cyc(mk('0, '0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b1, 4'd2, 2'b11));

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
